uart_cmd_ctrl: RTL and testbench

- Command controller behind the UART receiver; converts received ASCII bytes into control pulses and time-set loads for the watch/stopwatch core.
- Consumes the receiver's byte/done strobe.
- Decodes single-character commands and a 7-byte time-set sequence ('T' + hhmmss).
- Enforces digit/range checking and an inter-byte timeout; reports errors with a pulse.

---
 rtl/uart_cmd_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: turns bytes from the UART receiver into control pulses and
// time-set loads for the watch/stopwatch core.
//   Single-character commands: R/r run-stop, C/c clear, M/m mode;
//   CR, LF and space are ignored; 'T'/'t' + six digits (hhmmss) loads a time.
//   Time-set digits are range checked, and the sequence times out if no byte
//   arrives for TIMEOUT_CYC cycles. Rejected input pulses o_cmd_err.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   rx_data, rx_done   received byte and its one-cycle strobe
//   o_run_stop, o_clear, o_mode, o_set_valid, o_cmd_err   one-cycle pulses
//   o_set_hour/min/sec binary time, updated only with o_set_valid
// Optional echo (macro UART_CMD_ECHO_EN): o_tx_data, o_tx_start, tx_busy.
//   Each byte that does not cause an error is echoed, if tx_busy is low.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       o_run_stop,
    output logic       o_clear,
    output logic       o_mode,
    output logic       o_set_valid,
    output logic [4:0] o_set_hour,
    output logic [5:0] o_set_min,
    output logic [5:0] o_set_sec,
`ifdef UART_CMD_ECHO_EN
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    input  logic       tx_busy,
`endif
    output logic       o_cmd_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;

    state_t            state, state_n;
    logic [2:0]        idx, idx_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [5:0][3:0]   digits, digits_n;
    logic              run_stop_n, clear_n, mode_n, set_valid_n, cmd_err_n;
    logic [4:0]        set_hour_n;
    logic [5:0]        set_min_n, set_sec_n;
    logic [6:0]        hr_c, mn_c, sc_c;
    logic              is_digit_c;

    // Two-digit decimal values of the collected buffer
    assign hr_c = 7'(digits[0]) * 7'd10 + 7'(digits[1]);
    assign mn_c = 7'(digits[2]) * 7'd10 + 7'(digits[3]);
    assign sc_c = 7'(digits[4]) * 7'd10 + 7'(digits[5]);

    assign is_digit_c = (rx_data >= 8'h30) && (rx_data <= 8'h39);

`ifdef UART_CMD_ECHO_EN
    logic [7:0] tx_data_n;
    logic       tx_start_n;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        cnt_n       = cnt;
        digits_n    = digits;
        run_stop_n  = 1'b0;
        clear_n     = 1'b0;
        mode_n      = 1'b0;
        set_valid_n = 1'b0;
        cmd_err_n   = 1'b0;
        set_hour_n  = o_set_hour;
        set_min_n   = o_set_min;
        set_sec_n   = o_set_sec;

        case (state)
            IDLE: begin
                if (rx_done) begin
                    case (rx_data)
                        8'h52, 8'h72: run_stop_n = 1'b1;
                        8'h43, 8'h63: clear_n    = 1'b1;
                        8'h4D, 8'h6D: mode_n     = 1'b1;
                        8'h54, 8'h74: begin
                            state_n  = COLLECT;
                            idx_n    = 3'd0;
                            cnt_n    = '0;
                            digits_n = '0;
                        end
                        8'h0D, 8'h0A, 8'h20: ;
                        default: cmd_err_n = 1'b1;
                    endcase
                end
            end
            COLLECT: begin
                if (rx_done) begin
                    if (is_digit_c) begin
                        // ASCII '0'..'9' carry their value in the low nibble
                        digits_n[idx] = rx_data[3:0];
                        idx_n         = idx + 3'd1;
                        cnt_n         = '0;
                        if (idx == 3'd5) state_n = CHECK;
                    end else begin
                        cmd_err_n = 1'b1;
                        state_n   = IDLE;
                        idx_n     = 3'd0;
                        digits_n  = '0;
                    end
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    cmd_err_n = 1'b1;
                    state_n   = IDLE;
                    idx_n     = 3'd0;
                    cnt_n     = '0;
                    digits_n  = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            CHECK: begin
                // Any byte arriving here is dropped without error
                if (hr_c <= 7'd23 && mn_c <= 7'd59 && sc_c <= 7'd59) begin
                    set_valid_n = 1'b1;
                    set_hour_n  = hr_c[4:0];
                    set_min_n   = mn_c[5:0];
                    set_sec_n   = sc_c[5:0];
                end else begin
                    cmd_err_n = 1'b1;
                end
                state_n  = IDLE;
                idx_n    = 3'd0;
                cnt_n    = '0;
                digits_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef UART_CMD_ECHO_EN
    // Echo every accepted byte that was not rejected, when the transmitter is free
    always_comb begin
        tx_start_n = rx_done && !cmd_err_n && (state != CHECK) && !tx_busy;
        tx_data_n  = tx_start_n ? rx_data : o_tx_data;
    end
`endif

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 3'd0;
            cnt         <= '0;
            digits      <= '0;
            o_run_stop  <= 1'b0;
            o_clear     <= 1'b0;
            o_mode      <= 1'b0;
            o_set_valid <= 1'b0;
            o_cmd_err   <= 1'b0;
            o_set_hour  <= 5'd0;
            o_set_min   <= 6'd0;
            o_set_sec   <= 6'd0;
`ifdef UART_CMD_ECHO_EN
            o_tx_data   <= 8'd0;
            o_tx_start  <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            digits      <= digits_n;
            o_run_stop  <= run_stop_n;
            o_clear     <= clear_n;
            o_mode      <= mode_n;
            o_set_valid <= set_valid_n;
            o_cmd_err   <= cmd_err_n;
            o_set_hour  <= set_hour_n;
            o_set_min   <= set_min_n;
            o_set_sec   <= set_sec_n;
`ifdef UART_CMD_ECHO_EN
            o_tx_data   <= tx_data_n;
            o_tx_start  <= tx_start_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Testbench for uart_cmd_ctrl: table of single-byte commands plus
// hand-written time-set, abort, timeout and reset sequences.
module tb_uart_cmd_ctrl;

    localparam int unsigned TO = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       o_run_stop, o_clear, o_mode, o_set_valid, o_cmd_err;
    logic [4:0] o_set_hour;
    logic [5:0] o_set_min, o_set_sec;
`ifdef UART_CMD_ECHO_EN
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       tx_busy = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    uart_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .o_run_stop (o_run_stop),
        .o_clear    (o_clear),
        .o_mode     (o_mode),
        .o_set_valid(o_set_valid),
        .o_set_hour (o_set_hour),
        .o_set_min  (o_set_min),
        .o_set_sec  (o_set_sec),
`ifdef UART_CMD_ECHO_EN
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .tx_busy    (tx_busy),
`endif
        .o_cmd_err  (o_cmd_err)
    );

    always #5 clk = ~clk;

    // Pulse bits: {run_stop, clear, mode, set_valid, cmd_err}
    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_RUN  = 5'b10000;
    localparam logic [4:0] P_CLR  = 5'b01000;
    localparam logic [4:0] P_MODE = 5'b00100;
    localparam logic [4:0] P_SET  = 5'b00010;
    localparam logic [4:0] P_ERR  = 5'b00001;

    typedef struct {
        logic [7:0] data;
        logic [4:0] exp;
    } vec_t;

    function automatic logic [4:0] pulses();
        return {o_run_stop, o_clear, o_mode, o_set_valid, o_cmd_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Strobe one byte; returns on the falling edge after the accepting edge,
    // which is inside the cycle where a registered response is visible.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'hA5;
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s);
        chk({name, " hour"}, 32'(o_set_hour), 32'(h));
        chk({name, " min"},  32'(o_set_min),  32'(m));
        chk({name, " sec"},  32'(o_set_sec),  32'(s));
    endtask

    // 'T' + six digits; response is checked two cycles after the last strobe
    task automatic timeset(input string name, input logic [47:0] ds, input logic ok,
                           input int h, input int m, input int s);
        logic [7:0] b;
        send(8'h54);
        chk({name, " after T"}, 32'(pulses()), 32'(P_NONE));
        for (int i = 0; i < 6; i++) begin
            b = ds[47 - 8*i -: 8];
            send(b);
            chk({name, " digit"}, 32'(pulses()), 32'(P_NONE));
        end
        @(negedge clk);
        chk({name, " result"}, 32'(pulses()), 32'(ok ? P_SET : P_ERR));
        check_time(name, h, m, s);
        @(negedge clk);
        chk({name, " result ends"}, 32'(pulses()), 32'(P_NONE));
    endtask

    vec_t vecs[12];
    int   first_err;
    int   n_err;

    initial begin
        vecs[0]  = '{8'h52, P_RUN};   // R
        vecs[1]  = '{8'h63, P_CLR};   // c
        vecs[2]  = '{8'h4D, P_MODE};  // M
        vecs[3]  = '{8'h72, P_RUN};   // r
        vecs[4]  = '{8'h43, P_CLR};   // C
        vecs[5]  = '{8'h6D, P_MODE};  // m
        vecs[6]  = '{8'h0D, P_NONE};  // CR
        vecs[7]  = '{8'h0A, P_NONE};  // LF
        vecs[8]  = '{8'h20, P_NONE};  // space
        vecs[9]  = '{8'h78, P_ERR};   // x
        vecs[10] = '{8'h31, P_ERR};   // '1' outside a sequence
        vecs[11] = '{8'h5A, P_ERR};   // Z

        rst = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset pulses", 32'(pulses()), 32'(P_NONE));
        check_time("reset", 0, 0, 0);
        rst = 1'b0;

        // rx_data without rx_done must be ignored
        rx_data = 8'h52;
        repeat (4) @(negedge clk);
        chk("no strobe", 32'(pulses()), 32'(P_NONE));

        foreach (vecs[i]) begin
            send(vecs[i].data);
            chk($sformatf("vec%0d pulse", i), 32'(pulses()), 32'(vecs[i].exp));
            @(negedge clk);
            chk($sformatf("vec%0d one cycle", i), 32'(pulses()), 32'(P_NONE));
        end

        timeset("ts123456", {"1","2","3","4","5","6"}, 1'b1, 12, 34, 56);
        timeset("ts240000", {"2","4","0","0","0","0"}, 1'b0, 12, 34, 56);
        timeset("ts235959", {"2","3","5","9","5","9"}, 1'b1, 23, 59, 59);
        timeset("ts236000", {"2","3","6","0","0","0"}, 1'b0, 23, 59, 59);

        // Non-digit aborts the sequence
        send(8'h54); send(8'h30); send(8'h39);
        chk("abort before x", 32'(pulses()), 32'(P_NONE));
        send(8'h78);
        chk("abort err", 32'(pulses()), 32'(P_ERR));
        send(8'h52);
        chk("abort then R", 32'(pulses()), 32'(P_RUN));
        check_time("abort keeps", 23, 59, 59);

        // Inter-byte timeout
        send(8'h54); send(8'h31);
        first_err = -1;
        n_err = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (pulses() == P_ERR) begin
                n_err++;
                if (first_err < 0) first_err = i;
            end
        end
        chk("timeout err count", 32'(n_err), 32'd1);
        chk("timeout window", 32'((first_err >= 45) && (first_err <= 55)), 32'd1);
        send(8'h43);
        chk("timeout then C", 32'(pulses()), 32'(P_CLR));

        // Reset in the middle of a sequence
        send(8'h54); send(8'h30); send(8'h31);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset pulses", 32'(pulses()), 32'(P_NONE));
        check_time("midreset", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        timeset("ts000000", {"0","0","0","0","0","0"}, 1'b1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
